// File: rtl/pc_fetch_block_pkg.sv
// Shared widths, bubble/halt encodings and fetch FSM state type for the PC fetch stage.
package pc_fetch_block_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INS_W   = 20;
  localparam logic [19:0] NOP_INS = 20'h00000;
  localparam logic [3:0]  HALT_OP = 4'hF;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_REDIRECT = 2'd1,
    S_HALT     = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_block_if.sv
// Fetch-stage bus: stall/redirect controls and program-memory in, PC/instruction/status out.
interface pc_fetch_block_if #(
  parameter int unsigned ADDR_W = pc_fetch_block_pkg::ADDR_W,
  parameter int unsigned INS_W  = pc_fetch_block_pkg::INS_W
);

  logic              stall;
  logic              stall_pm;
  logic              jump;
  logic [ADDR_W-1:0] jmp_loc;
  logic [INS_W-1:0]  ins_pm;
  logic [ADDR_W-1:0] pm_addr;
  logic [INS_W-1:0]  ins_out;
  logic              ins_valid;
  logic              halted;
  logic [7:0]        stall_cnt;

  // Controller / program-memory side
  modport master (
    output stall, stall_pm, jump, jmp_loc, ins_pm,
    input  pm_addr, ins_out, ins_valid, halted, stall_cnt
  );

  // Fetch block side
  modport slave (
    input  stall, stall_pm, jump, jmp_loc, ins_pm,
    output pm_addr, ins_out, ins_valid, halted, stall_cnt
  );

endinterface

// File: rtl/pc_fetch_block_pc_reg.sv
// Program counter register: load has priority over increment; increment wraps naturally.
module pc_reg #(
  parameter int unsigned ADDR_W = pc_fetch_block_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (inc) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_block.sv
// Fetch stage: PC sequencing with stall/bubble/redirect handling and a sticky HALT state.
module pc_fetch_block #(
  parameter int unsigned      ADDR_W  = pc_fetch_block_pkg::ADDR_W,
  parameter int unsigned      INS_W   = pc_fetch_block_pkg::INS_W,
  parameter logic [INS_W-1:0] NOP_INS = pc_fetch_block_pkg::NOP_INS
) (
  input logic              clk,
  input logic              reset,
  pc_fetch_block_if.slave  bus
);

  import pc_fetch_block_pkg::*;

  fetch_state_e      state;
  logic [INS_W-1:0]  ins_out_q;
  logic              ins_valid_q;
  logic              halted_q;
  logic [7:0]        stall_cnt_q;
  logic [ADDR_W-1:0] pc_q;
  logic              pc_load;
  logic              pc_inc;
  logic              fetch_real;

  // Only an unstalled, unsquashed, non-jumping RUN cycle captures ins_pm
  always_comb begin
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    fetch_real = 1'b0;
    unique case (state)
      S_RUN: begin
        if (bus.jump) begin
          pc_load = 1'b1;
        end else begin
          pc_inc     = !bus.stall;
          fetch_real = !bus.stall && !bus.stall_pm;
        end
      end
      S_REDIRECT: pc_inc = !bus.stall;
      default: ;
    endcase
  end

  pc_reg #(.ADDR_W(ADDR_W)) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load),
    .inc   (pc_inc),
    .d     (bus.jmp_loc),
    .q     (pc_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_RUN;
      ins_out_q   <= NOP_INS;
      ins_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (bus.stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 8'd1;
      end
      unique case (state)
        S_RUN: begin
          if (bus.jump) begin
            ins_out_q   <= NOP_INS;
            ins_valid_q <= 1'b0;
            state       <= S_REDIRECT;
          end else if (bus.stall_pm) begin
            ins_out_q   <= NOP_INS;
            ins_valid_q <= 1'b0;
          end else if (fetch_real) begin
            ins_out_q   <= bus.ins_pm;
            ins_valid_q <= 1'b1;
            if (bus.ins_pm[INS_W-1 -: 4] == HALT_OP) begin
              state    <= S_HALT;
              halted_q <= 1'b1;
            end
          end
        end
        S_REDIRECT: begin
          ins_out_q   <= NOP_INS;
          ins_valid_q <= 1'b0;
          state       <= S_RUN;
        end
        S_HALT: begin
          ins_valid_q <= 1'b0;
        end
        default: state <= S_RUN;
      endcase
    end
  end

  assign bus.pm_addr   = pc_q;
  assign bus.ins_out   = ins_out_q;
  assign bus.ins_valid = ins_valid_q;
  assign bus.halted    = halted_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pc_fetch_block.sv
// Directed bench for pc_fetch_block; program memory returns {4'h1, 8'h00, addr} unless overridden.
module tb_pc_fetch_block;

  logic clk;
  logic reset;
  logic use_fixed;
  logic [19:0] fixed_ins;
  int n_cmp;
  int n_err;

  pc_fetch_block_if #(.ADDR_W(8), .INS_W(20)) bus ();

  pc_fetch_block #(.ADDR_W(8), .INS_W(20), .NOP_INS(20'h00000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.ins_pm = use_fixed ? fixed_ins : {4'h1, 8'h00, bus.pm_addr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] pc, input logic [19:0] ins,
                           input logic vld, input logic hlt, input logic [7:0] cnt);
    check({tag, ".pm_addr"},   32'(bus.pm_addr),   32'(pc));
    check({tag, ".ins_out"},   32'(bus.ins_out),   32'(ins));
    check({tag, ".ins_valid"}, 32'(bus.ins_valid), 32'(vld));
    check({tag, ".halted"},    32'(bus.halted),    32'(hlt));
    check({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(cnt));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    use_fixed = 1'b1;
    fixed_ins = 20'h11111;
    bus.stall = 1'b0;
    bus.stall_pm = 1'b0;
    bus.jump = 1'b0;
    bus.jmp_loc = 8'h00;
    #1;
    check_all("reset_async", 8'h00, 20'h00000, 1'b0, 1'b0, 8'h00);
    step();
    step();
    reset = 1'b0;

    // Straight-line fetch of a fixed word
    step(); check_all("run1", 8'h01, 20'h11111, 1'b1, 1'b0, 8'h00);
    step(); check_all("run2", 8'h02, 20'h11111, 1'b1, 1'b0, 8'h00);
    step(); check_all("run3", 8'h03, 20'h11111, 1'b1, 1'b0, 8'h00);
    use_fixed = 1'b0;
    step();
    step(); check_all("run5", 8'h05, 20'h10004, 1'b1, 1'b0, 8'h00);

    // Stall with bubble: PC holds, NOP issued
    bus.stall = 1'b1; bus.stall_pm = 1'b1;
    step(); check_all("bubble1", 8'h05, 20'h00000, 1'b0, 1'b0, 8'h01);
    step(); check_all("bubble2", 8'h05, 20'h00000, 1'b0, 1'b0, 8'h02);
    bus.stall = 1'b0; bus.stall_pm = 1'b0;
    step(); check_all("resume", 8'h06, 20'h10005, 1'b1, 1'b0, 8'h02);

    // Plain stall holds everything
    bus.stall = 1'b1;
    step(); check_all("hold", 8'h06, 20'h10005, 1'b1, 1'b0, 8'h03);

    // Squash without stall: PC advances, NOP issued
    bus.stall = 1'b0; bus.stall_pm = 1'b1;
    step(); check_all("squash", 8'h07, 20'h00000, 1'b0, 1'b0, 8'h03);

    // Jump beats stall, one REDIRECT bubble, jump ignored in REDIRECT
    bus.stall_pm = 1'b0; bus.stall = 1'b1; bus.jump = 1'b1; bus.jmp_loc = 8'h40;
    step(); check_all("jump", 8'h40, 20'h00000, 1'b0, 1'b0, 8'h04);
    bus.stall = 1'b0; bus.jmp_loc = 8'h80;
    step(); check_all("redirect", 8'h41, 20'h00000, 1'b0, 1'b0, 8'h04);
    bus.jump = 1'b0;
    step(); check_all("post_jump", 8'h42, 20'h10041, 1'b1, 1'b0, 8'h04);

    // PC wrap 0xFF -> 0x00
    bus.jump = 1'b1; bus.jmp_loc = 8'hFE;
    step(); check("wrap_jump.pm_addr", 32'(bus.pm_addr), 32'h0000_00FE);
    bus.jump = 1'b0;
    step(); check("wrap_ff.pm_addr", 32'(bus.pm_addr), 32'h0000_00FF);
    step(); check_all("wrap_00", 8'h00, 20'h100FF, 1'b1, 1'b0, 8'h04);

    // Reset in the middle of REDIRECT
    bus.jump = 1'b1; bus.jmp_loc = 8'h30;
    step(); check("pre_rst.pm_addr", 32'(bus.pm_addr), 32'h0000_0030);
    bus.jump = 1'b0;
    #3 reset = 1'b1;
    #1 check_all("rst_redirect", 8'h00, 20'h00000, 1'b0, 1'b0, 8'h00);
    #1 reset = 1'b0;
    step(); check_all("first_fetch", 8'h01, 20'h10000, 1'b1, 1'b0, 8'h00);
    step();

    // HALT opcode
    use_fixed = 1'b1; fixed_ins = 20'hF0000;
    step(); check_all("halt_edge", 8'h03, 20'hF0000, 1'b1, 1'b1, 8'h00);
    use_fixed = 1'b0;
    bus.jump = 1'b1; bus.jmp_loc = 8'h55; bus.stall = 1'b1; bus.stall_pm = 1'b1;
    step(); check_all("halt_hold", 8'h03, 20'hF0000, 1'b0, 1'b1, 8'h01);
    bus.jump = 1'b0; bus.stall = 1'b0; bus.stall_pm = 1'b0;
    step(); check_all("halt_idle", 8'h03, 20'hF0000, 1'b0, 1'b1, 8'h01);
    #3 reset = 1'b1;
    #1 check_all("rst_halt", 8'h00, 20'h00000, 1'b0, 1'b0, 8'h00);
    #1 reset = 1'b0;
    step(); check_all("restart", 8'h01, 20'h10000, 1'b1, 1'b0, 8'h00);

    // Stall counter saturation
    bus.stall = 1'b1;
    for (int i = 0; i < 254; i++) step();
    check("cnt_fe", 32'(bus.stall_cnt), 32'h0000_00FE);
    for (int i = 0; i < 46; i++) step();
    check_all("cnt_sat", 8'h01, 20'h10000, 1'b1, 1'b0, 8'hFF);
    bus.stall = 1'b0;
    step(); check_all("after_sat", 8'h02, 20'h10001, 1'b1, 1'b0, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_block.md
PC_FETCH_BLOCK -- requirements
Module: pc_fetch_block

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, program-memory address width.
REQ-002 SHALL have parameter INS_W, default 20, instruction width.
REQ-003 SHALL have parameter NOP_INS, default 20'h00000, bubble instruction.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  hold request from stall control; freezes PC.
REQ-007 SHALL have port stall_pm  input  1  bubble request from stall control; squashes fetched instruction.
REQ-008 SHALL have port jump  input  1  redirect request, one-cycle pulse.
REQ-009 SHALL have port jmp_loc  input  ADDR_W  redirect target address.
REQ-010 SHALL have port ins_pm  input  INS_W  instruction read from program memory at pm_addr.
REQ-011 SHALL have port pm_addr  output  ADDR_W  program counter, drives program memory.
REQ-012 SHALL have port ins_out  output  INS_W  registered instruction to decode stage.
REQ-013 SHALL have port ins_valid  output  1  ins_out is a real fetched instruction, not a bubble.
REQ-014 SHALL have port halted  output  1  fetch permanently stopped by HALT opcode.
REQ-015 SHALL have port stall_cnt  output  8  saturating count of cycles with stall=1.

Function
REQ-016 SHALL implement FSM states RUN, REDIRECT, HALT.
REQ-017 In RUN, stall=0, stall_pm=0, jump=0: pm_addr <= pm_addr+1; ins_out <= ins_pm; ins_valid <= 1.
REQ-018 In RUN, stall=1, stall_pm=0: pm_addr, ins_out, ins_valid hold.
REQ-019 In RUN, stall_pm=1, stall=1: pm_addr holds; ins_out <= NOP_INS; ins_valid <= 0.
REQ-020 In RUN, stall_pm=1, stall=0: pm_addr <= pm_addr+1; ins_out <= NOP_INS; ins_valid <= 0.
REQ-021 jump=1 in RUN SHALL take priority over stall/stall_pm: pm_addr <= jmp_loc; ins_out <= NOP_INS; ins_valid <= 0; next state REDIRECT.
REQ-022 REDIRECT SHALL last exactly one cycle: ins_out <= NOP_INS, ins_valid <= 0, pm_addr <= pm_addr+1 unless stall=1 (then hold); jump ignored; next state RUN.
REQ-023 PC increment SHALL wrap modulo 2^ADDR_W (8'hFF -> 8'h00), no flag.
REQ-024 When RUN loads ins_out with ins_pm[INS_W-1:INS_W-4]==4'hF, next state SHALL be HALT in the same edge; halted=1 from that edge.
REQ-025 In HALT: pm_addr and ins_out frozen, ins_valid <= 0, stall/stall_pm/jump ignored; only reset exits.
REQ-026 stall_cnt SHALL increment on every rising edge with stall=1 in any state, saturate at 8'hFF.
REQ-027 Latency: ins_pm sampled at edge N appears on ins_out after edge N; pm_addr change visible after same edge.

Reset
REQ-028 reset=1 SHALL immediately force pm_addr=0, ins_out=NOP_INS, ins_valid=0, halted=0, stall_cnt=0, state=RUN, independent of clk.
REQ-029 reset asserted mid-stall, mid-REDIRECT or in HALT SHALL discard all state; first fetch after release is address 0.
REQ-030 On first rising edge with reset=0, normal RUN rules SHALL apply.

Structure
REQ-031 Shared package SHALL hold ADDR_W, INS_W, NOP_INS, HALT opcode 4'hF, and FSM state encoding.
REQ-032 A sub-module pc_reg (load/increment/hold register with wrap) is natural; all else in one block.

Verification
REQ-033 Reset release, stall=0, ins_pm=20'h11111 for 3 cycles -> pm_addr 0,1,2,3; ins_valid=1 from first edge.
REQ-034 pm_addr=5, stall=1, stall_pm=1 for 2 cycles -> pm_addr stays 5, ins_out=20'h00000, ins_valid=0; stall_cnt=2.
REQ-035 jump=1, jmp_loc=8'h40 with stall=1 -> pm_addr=8'h40, one REDIRECT bubble, then ins_valid=1 at address 8'h41.
REQ-036 pm_addr=8'hFF, no stall -> next pm_addr=8'h00.
REQ-037 ins_pm=20'hF0000 fetched -> halted=1, pm_addr frozen, later jump ignored; reset pulse mid-cycle -> pm_addr=0, halted=0 immediately.
REQ-038 stall held 300 cycles -> stall_cnt saturates at 8'hFF.
